// File: rtl/maf_tm_pipe.sv
// Timing model and alignment checker for a pipelined FP unit under test.
// Delays op valid/operands by LATENCY stages, tracks in-flight ops, checks the DUT's res_rdy.
module maf_tm_pipe #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 3,
    parameter int LATENCY = 4,
    localparam int CNT_W  = $clog2(LATENCY + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_vld,
    input  logic [NUM_OPS*DATA_W-1:0] op_data,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      chk_en,
    input  logic                      res_rdy,
    output logic                      op_vld_rx,
    output logic [NUM_OPS*DATA_W-1:0] op_data_rx,
    output logic [CNT_W-1:0]          inflight_cnt,
    output logic                      drop_err,
    output logic                      align_err,
    output logic [15:0]               mism_cnt
);

    localparam int OP_W = NUM_OPS * DATA_W;

    logic [LATENCY-1:0] v_q, v_d;
    logic [OP_W-1:0]    d_q [LATENCY];
    logic [OP_W-1:0]    d_d [LATENCY];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic               align_q, align_d;
    logic [15:0]        mism_q, mism_d;

    logic adv_s;
    logic accept_s;
    logic exit_s;
    logic chk_s;

    assign adv_s    = ~stall & ~flush;
    assign accept_s = adv_s & op_vld;
    assign exit_s   = adv_s & v_q[LATENCY-1];
    // The check compares against the current last-stage valid, with no extra delay.
    assign chk_s    = chk_en & adv_s & (res_rdy != v_q[LATENCY-1]);

    // Pipeline next state: flush clears valids, stall holds, otherwise shift.
    always_comb begin
        v_d    = v_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        for (int i = 0; i < LATENCY; i++) begin
            d_d[i] = d_q[i];
        end
        if (flush) begin
            v_d   = '0;
            cnt_d = '0;
        end else if (stall) begin
            drop_d = drop_q | op_vld;
        end else begin
            v_d[0] = op_vld;
            d_d[0] = op_data;
            for (int i = 1; i < LATENCY; i++) begin
                v_d[i] = v_q[i-1];
                d_d[i] = d_q[i-1];
            end
            if (accept_s && !exit_s) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (exit_s && !accept_s) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Alignment checker next state: sticky flag and saturating mismatch counter.
    always_comb begin
        align_d = align_q | chk_s;
        if (chk_s && (mism_q != 16'hFFFF)) begin
            mism_d = mism_q + 16'd1;
        end else begin
            mism_d = mism_q;
        end
    end

    // State registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            align_q <= 1'b0;
            mism_q  <= 16'd0;
            for (int i = 0; i < LATENCY; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            align_q <= align_d;
            mism_q  <= mism_d;
            for (int i = 0; i < LATENCY; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign op_vld_rx    = v_q[LATENCY-1];
    assign op_data_rx   = d_q[LATENCY-1];
    assign inflight_cnt = cnt_q;
    assign drop_err     = drop_q;
    assign align_err    = align_q;
    assign mism_cnt     = mism_q;

endmodule
